// File: rtl/otp_ctrl_arb.sv
// otp_ctrl_arb: round-robin arbiter/sequencer for the shared OTP macro command port.
// Optional response watchdog enabled by defining OTP_CTRL_ARB_TIMEOUT_EN.
module otp_ctrl_arb #(
    parameter int NumReq           = 4,
    parameter int TimeoutCycles    = 1024,
    parameter int OtpCmdWidth      = 3,
    parameter int OtpSizeWidth     = 2,
    parameter int OtpIfWidth       = 16,
    parameter int OtpAddrWidth     = 10,
    parameter int ScrmblBlockWidth = 64,
    parameter int OtpErrWidth      = 3
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [3:0]                       escalate_en_i,
    input  logic [NumReq-1:0]                req_i,
    input  logic [NumReq*OtpCmdWidth-1:0]    cmd_i,
    input  logic [NumReq*OtpSizeWidth-1:0]   size_i,
    input  logic [NumReq*OtpIfWidth-1:0]     wdata_i,
    input  logic [NumReq*OtpAddrWidth-1:0]   addr_i,
    output logic [NumReq-1:0]                gnt_o,
    output logic [NumReq-1:0]                rvalid_o,
    output logic [ScrmblBlockWidth-1:0]      rdata_o,
    output logic [OtpErrWidth-1:0]           err_o,
    output logic                             otp_req_o,
    output logic [OtpCmdWidth-1:0]           otp_cmd_o,
    output logic [OtpSizeWidth-1:0]          otp_size_o,
    output logic [OtpIfWidth-1:0]            otp_wdata_o,
    output logic [OtpAddrWidth-1:0]          otp_addr_o,
    input  logic                             otp_gnt_i,
    input  logic                             otp_rvalid_i,
    input  logic [ScrmblBlockWidth-1:0]      otp_rdata_i,
    input  logic [OtpErrWidth-1:0]           otp_err_i,
    output logic                             idle_o,
    output logic                             fsm_err_o,
    output logic                             timeout_err_o
);
    localparam int SelW = $clog2(NumReq);
    localparam logic [3:0] LcTxOff = 4'b1010;

    typedef enum logic [9:0] {
        IdleSt  = 10'b1010011001,
        ReqSt   = 10'b0101111001,
        WaitSt  = 10'b1010000110,
        ErrorSt = 10'b0101100110
    } state_e;

    state_e st_q, st_d;
    logic [SelW-1:0] sel_q, sel_d, ptr_q, ptr_d, pick, idx;
    logic esc, busy, to_hit;

    assign esc  = escalate_en_i != LcTxOff;
    assign busy = st_q == ReqSt || st_q == WaitSt;

    assign otp_cmd_o   = otp_req_o ? cmd_i[sel_q*OtpCmdWidth +: OtpCmdWidth] : '0;
    assign otp_size_o  = otp_req_o ? size_i[sel_q*OtpSizeWidth +: OtpSizeWidth] : '0;
    assign otp_wdata_o = otp_req_o ? wdata_i[sel_q*OtpIfWidth +: OtpIfWidth] : '0;
    assign otp_addr_o  = otp_req_o ? addr_i[sel_q*OtpAddrWidth +: OtpAddrWidth] : '0;

`ifdef OTP_CTRL_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] cnt_q;
    logic to_err_q;
    assign to_hit        = busy && cnt_q == CntW'(TimeoutCycles - 1);
    assign timeout_err_o = to_err_q;
    // Watchdog restarts with each new command and counts while it is in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            to_err_q <= 1'b0;
        end else begin
            cnt_q    <= (st_q == IdleSt && st_d == ReqSt) ? '0 : busy ? cnt_q + 1'b1 : cnt_q;
            to_err_q <= to_err_q | to_hit;
        end
    end
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 32'(TimeoutCycles);
    assign to_hit        = 1'b0;
    assign timeout_err_o = 1'b0;
`endif

    // Round-robin search: the smallest offset from ptr_q with an active request wins.
    always_comb begin
        pick = ptr_q;
        idx  = ptr_q;
        for (int k = NumReq - 1; k >= 0; k--) begin
            idx = SelW'((int'(ptr_q) + k) % NumReq);
            if (req_i[idx]) pick = idx;
        end
    end

    // Next state and outputs; escalation and timeout override every other transition.
    always_comb begin
        st_d      = st_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        idle_o    = 1'b0;
        otp_req_o = 1'b0;
        gnt_o     = '0;
        rvalid_o  = '0;
        rdata_o   = '0;
        err_o     = '0;
        case (st_q)
            IdleSt: begin
                idle_o = 1'b1;
                if (otp_rvalid_i) begin
                    st_d = ErrorSt;
                end else if (|req_i) begin
                    st_d  = ReqSt;
                    sel_d = pick;
                end
            end
            ReqSt: begin
                otp_req_o = 1'b1;
                if (otp_gnt_i) begin
                    gnt_o = NumReq'(1) << sel_q;
                    st_d  = WaitSt;
                end
                if (otp_rvalid_i) st_d = ErrorSt;
            end
            WaitSt: begin
                if (otp_rvalid_i) begin
                    rvalid_o = NumReq'(1) << sel_q;
                    rdata_o  = otp_rdata_i;
                    err_o    = otp_err_i;
                    ptr_d    = sel_q == SelW'(NumReq - 1) ? '0 : sel_q + 1'b1;
                    st_d     = IdleSt;
                end
            end
            ErrorSt: st_d = ErrorSt;
            default: st_d = ErrorSt;
        endcase
        if (esc || to_hit) st_d = ErrorSt;
        fsm_err_o = st_q != ErrorSt && st_d == ErrorSt;
    end

    // State, owner index and priority pointer registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            st_q  <= IdleSt;
            sel_q <= '0;
            ptr_q <= '0;
        end else begin
            st_q  <= st_d;
            sel_q <= sel_d;
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: tb/tb_otp_ctrl_arb.sv
// tb_otp_ctrl_arb: vector table, directed corner sequences and random traffic against a reference model.
module tb_otp_ctrl_arb;
    localparam int N = 4;
    localparam int TO = 16;
    localparam logic [3:0] OFF = 4'b1010, ON = 4'b0101;
    localparam logic [109:0] IDLE_ONLY = 110'd4;

    typedef struct {
        logic [3:0]  req;
        logic        gnt, rv;
        logic [63:0] rd;
        logic [3:0]  eg, er;
        logic        erq;
        int          es;
        logic        ei;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] esc, req;
    logic [2:0]  cmd_a   [N];
    logic [1:0]  size_a  [N];
    logic [15:0] wdata_a [N];
    logic [9:0]  addr_a  [N];
    logic [N*3-1:0]  cmd_f;
    logic [N*2-1:0]  size_f;
    logic [N*16-1:0] wdata_f;
    logic [N*10-1:0] addr_f;
    logic ogn, orv;
    logic [63:0] ordata;
    logic [2:0] oerr;
    logic [3:0] gnt, rvo;
    logic [63:0] rdata;
    logic [2:0] err, ocmd;
    logic oreq, idle, ferr, toerr;
    logic [1:0] osize;
    logic [15:0] owdata;
    logic [9:0] oaddr;
    logic [109:0] got_v;

    int n_chk = 0, n_err = 0, cyc = 0;
    int m_owner = -1, m_ptr = 0, m_tc = 0;
    bit m_gr = 0, m_dead = 0, m_to = 0;
    vec_t tbl[$];
    int rr_t[$], rr_i[$];

    always #5 clk = ~clk;

    always_comb begin
        cmd_f = '0;
        size_f = '0;
        wdata_f = '0;
        addr_f = '0;
        for (int i = 0; i < N; i++) begin
            cmd_f[i*3 +: 3]    = cmd_a[i];
            size_f[i*2 +: 2]   = size_a[i];
            wdata_f[i*16 +: 16] = wdata_a[i];
            addr_f[i*10 +: 10] = addr_a[i];
        end
    end

    assign got_v = {gnt, rvo, rdata, err, oreq, ocmd, osize, owdata, oaddr, idle, ferr, toerr};

    otp_ctrl_arb #(.NumReq(N), .TimeoutCycles(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .escalate_en_i(esc), .req_i(req),
        .cmd_i(cmd_f), .size_i(size_f), .wdata_i(wdata_f), .addr_i(addr_f),
        .gnt_o(gnt), .rvalid_o(rvo), .rdata_o(rdata), .err_o(err),
        .otp_req_o(oreq), .otp_cmd_o(ocmd), .otp_size_o(osize), .otp_wdata_o(owdata), .otp_addr_o(oaddr),
        .otp_gnt_i(ogn), .otp_rvalid_i(orv), .otp_rdata_i(ordata), .otp_err_i(oerr),
        .idle_o(idle), .fsm_err_o(ferr), .timeout_err_o(toerr)
    );

    task automatic chk(input string name, input logic [109:0] got, input logic [109:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic vec_t row(input logic [3:0] rq, input logic g, input logic v, input logic [63:0] d,
                                 input logic [3:0] eg, input logic [3:0] er, input logic erq, input int es, input logic ei);
        vec_t r;
        r.req = rq; r.gnt = g; r.rv = v; r.rd = d; r.eg = eg; r.er = er; r.erq = erq; r.es = es; r.ei = ei;
        return r;
    endfunction

    task automatic step();
        logic [3:0] e_gnt, e_rv;
        logic [63:0] e_rd;
        logic [2:0] e_err, e_cmd;
        logic [1:0] e_size;
        logic [15:0] e_wd;
        logic [9:0] e_ad;
        logic e_req, e_idle, e_ferr;
        int own_n, ptr_n, tc_n;
        bit gr_n, dead_n, to_n;
        e_gnt = '0; e_rv = '0; e_rd = '0; e_err = '0; e_cmd = '0; e_size = '0; e_wd = '0; e_ad = '0;
        e_req = 1'b0; e_idle = 1'b0; e_ferr = 1'b0;
        own_n = m_owner; ptr_n = m_ptr; tc_n = m_tc; gr_n = m_gr; dead_n = m_dead; to_n = m_to;
        if (!m_dead) begin
            if (m_owner < 0) begin
                e_idle = 1'b1;
                if (orv) dead_n = 1;
                else if (req != 0) begin
                    own_n = pick(req, m_ptr);
                    gr_n = 0;
                    tc_n = 0;
                end
            end else begin
                if (!m_gr) begin
                    e_req = 1'b1;
                    e_cmd = cmd_a[m_owner]; e_size = size_a[m_owner]; e_wd = wdata_a[m_owner]; e_ad = addr_a[m_owner];
                    if (ogn) begin
                        e_gnt = 4'b0001 << m_owner;
                        gr_n = 1;
                    end
                    if (orv) dead_n = 1;
                end else if (orv) begin
                    e_rv = 4'b0001 << m_owner;
                    e_rd = ordata;
                    e_err = oerr;
                    ptr_n = (m_owner + 1) % N;
                    own_n = -1;
                    gr_n = 0;
                end
`ifdef OTP_CTRL_ARB_TIMEOUT_EN
                if (m_tc == TO - 1) begin
                    dead_n = 1;
                    to_n = 1;
                end
                tc_n = m_tc + 1;
`endif
            end
            if (esc != OFF) dead_n = 1;
            e_ferr = dead_n;
        end
        #1;
        chk("model", got_v, {e_gnt, e_rv, e_rd, e_err, e_req, e_cmd, e_size, e_wd, e_ad, e_idle, e_ferr, m_to});
        if (!rst_n) begin
            own_n = -1; ptr_n = 0; tc_n = 0; gr_n = 0; dead_n = 0; to_n = 0;
        end
        m_owner = own_n; m_ptr = ptr_n; m_tc = tc_n; m_gr = gr_n; m_dead = dead_n; m_to = to_n;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; ogn = 1'b0; orv = 1'b0; esc = OFF; ordata = '0; oerr = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            cmd_a[i] = 3'(i + 1);
            size_a[i] = 2'(i);
            wdata_a[i] = 16'hA000 + 16'(i);
            addr_a[i] = 10'h100 + 10'(i);
        end
        rst_n = 1'b0; req = '0; ogn = 1'b0; orv = 1'b0; esc = OFF; ordata = '0; oerr = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("reset", got_v, IDLE_ONLY);

        tbl.push_back(row(4'b0100, 0, 0, 64'd0, 4'b0000, 4'b0000, 0, 0, 1));
        tbl.push_back(row(4'b0100, 0, 0, 64'd0, 4'b0000, 4'b0000, 1, 2, 0));
        tbl.push_back(row(4'b0100, 0, 0, 64'd0, 4'b0000, 4'b0000, 1, 2, 0));
        tbl.push_back(row(4'b0100, 1, 0, 64'd0, 4'b0100, 4'b0000, 1, 2, 0));
        tbl.push_back(row(4'b0000, 0, 0, 64'd0, 4'b0000, 4'b0000, 0, 0, 0));
        tbl.push_back(row(4'b0000, 0, 1, 64'h1234_5678_9ABC_DEF0, 4'b0000, 4'b0100, 0, 0, 0));
        tbl.push_back(row(4'b1111, 0, 0, 64'd0, 4'b0000, 4'b0000, 0, 0, 1));
        tbl.push_back(row(4'b1111, 1, 0, 64'd0, 4'b1000, 4'b0000, 1, 3, 0));
        tbl.push_back(row(4'b0111, 0, 1, 64'hA5, 4'b0000, 4'b1000, 0, 0, 0));
        tbl.push_back(row(4'b0011, 0, 0, 64'd0, 4'b0000, 4'b0000, 0, 0, 1));
        tbl.push_back(row(4'b0011, 1, 0, 64'd0, 4'b0001, 4'b0000, 1, 0, 0));
        tbl.push_back(row(4'b0010, 0, 1, 64'd0, 4'b0000, 4'b0001, 0, 0, 0));
        tbl.push_back(row(4'b0010, 0, 0, 64'd0, 4'b0000, 4'b0000, 0, 0, 1));
        tbl.push_back(row(4'b0010, 0, 0, 64'd0, 4'b0000, 4'b0000, 1, 1, 0));
        foreach (tbl[i]) begin
            req = tbl[i].req; ogn = tbl[i].gnt; orv = tbl[i].rv; ordata = tbl[i].rd;
            #1;
            chk("tbl", {gnt, rvo, rdata, oreq, oaddr, idle, ferr},
                {tbl[i].eg, tbl[i].er, (tbl[i].er != 0) ? tbl[i].rd : 64'd0, tbl[i].erq,
                 tbl[i].erq ? 10'h100 + 10'(tbl[i].es) : 10'd0, tbl[i].ei, 1'b0});
            step();
        end

        do_reset();
        for (int t = 0; t < 15; t++) begin
            req = 4'b1111; ogn = (t % 3 == 1); orv = (t % 3 == 2);
            #1;
            if (gnt != 0) begin
                rr_t.push_back(t);
                rr_i.push_back($clog2(gnt));
            end
            step();
        end
        chk("rr_count", 110'(rr_t.size()), 110'd5);
        for (int i = 0; i < 5; i++)
            if (i < rr_t.size()) chk("rr_order", 110'(rr_t[i] * 16 + rr_i[i]), 110'((3 * i + 1) * 16 + i % N));

        do_reset();
        orv = 1'b1;
        #1;
        chk("rv_idle_ferr", 110'(ferr), 110'd1);
        step();
        orv = 1'b0; req = 4'b1111; ogn = 1'b1;
        #1;
        chk("rv_idle_dead", 110'({idle, ferr}), 110'd0);
        repeat (5) begin
            #1;
            chk("rv_idle_nognt", 110'({gnt, oreq}), 110'd0);
            step();
        end

        do_reset();
        repeat (3) begin
            #1;
            chk("esc_off", 110'({idle, ferr}), 110'b10);
            step();
        end
        req = 4'b0001;
        step();
        ogn = 1'b1;
        step();
        req = '0; ogn = 1'b0; esc = ON; orv = 1'b1; ordata = 64'hCAFE;
        #1;
        chk("esc_wait", 110'({rvo, rdata, ferr}), 110'({4'b0001, 64'hCAFE, 1'b1}));
        step();
        esc = OFF; orv = 1'b0; req = 4'b1111; ogn = 1'b1;
        repeat (5) begin
            #1;
            chk("esc_dead", 110'({oreq, gnt, idle}), 110'd0);
            step();
        end

        do_reset();
        req = 4'b0010;
        step();
        ogn = 1'b1;
        step();
        ogn = 1'b0; req = '0; orv = 1'b1;
        step();
        orv = 1'b0; req = 4'b0100;
        step();
        ogn = 1'b1;
        step();
        ogn = 1'b0; req = '0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_wait", got_v, IDLE_ONLY);
        req = 4'b1111;
        step();
        ogn = 1'b1;
        #1;
        chk("rst_ptr", 110'({gnt, oaddr}), 110'({4'b0001, 10'h100}));
        step();

        do_reset();
        req = 4'b0001;
        step();
`ifdef OTP_CTRL_ARB_TIMEOUT_EN
        repeat (TO) begin
            #1;
            chk("to_wait", 110'({oreq, toerr}), 110'b10);
            step();
        end
        #1;
        chk("to_err", 110'({oreq, toerr, idle}), 110'b010);
        step();
`else
        repeat (40) begin
            #1;
            chk("no_to_wait", 110'({oreq, toerr}), 110'b10);
            step();
        end
`endif

        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (m_dead && $urandom_range(0, 7) == 0) rst_n = 1'b0;
            else rst_n = ($urandom_range(0, 499) != 0);
            esc = ($urandom_range(0, 199) == 0) ? 4'($urandom_range(0, 15)) : OFF;
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            for (int i = 0; i < N; i++) begin
                cmd_a[i] = 3'($urandom);
                size_a[i] = 2'($urandom);
                wdata_a[i] = 16'($urandom);
                addr_a[i] = 10'($urandom);
            end
            ogn = 1'($urandom);
            orv = (m_owner >= 0 && m_gr) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 299) == 0);
            ordata = {$urandom, $urandom};
            oerr = 3'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
